// File: rtl/usb_sie_tx.sv
// USB SIE transmit sequencer: emits PID, optional payload and CRC16 bytes to a UTMI
// transmitter, then holds an inter-packet gap before reporting completion.
module usb_sie_tx #(
  parameter int GAP_CYCLES = 16
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       pkt_start,
  input  logic [3:0] pkt_pid,
  input  logic       pkt_has_data,
  input  logic       pkt_zlp,
  input  logic [7:0] pl_data,
  input  logic       pl_valid,
  input  logic       pl_last,
  output logic       pl_ready,
  output logic [7:0] data_out,
  output logic       tx_valid,
  input  logic       tx_ready,
  output logic       busy,
  output logic       done,
  output logic       underrun,
  output logic [6:0] byte_cnt
);

  localparam int GW = $clog2(GAP_CYCLES + 1);

  // Handshake: a byte transfers on any rising edge where tx_valid && tx_ready;
  // data_out/tx_valid hold until that edge. pl_ready marks the edge a payload byte is taken.
  typedef enum logic [2:0] {
    IDLE_S, PID_S, DATA_S, CRC_LO_S, CRC_HI_S, GAP_S
  } state_t;

  state_t          state, state_n;
  logic [7:0]      data_out_n;
  logic            tx_valid_n;
  logic [15:0]     crc, crc_n;
  logic [6:0]      byte_cnt_n;
  logic            has_data_r, has_data_n;
  logic            zlp_r, zlp_n;
  logic            last_r, last_n;
  logic            cut_r, cut_n;
  logic [GW-1:0]   gap_cnt, gap_n;
  logic            underrun_n;
  logic            hs;
  logic            step;

  function automatic logic [15:0] crc16_upd(input logic [15:0] c, input logic [7:0] d);
    logic [15:0] r;
    r = c;
    for (int i = 0; i < 8; i++) begin
      r = (r[0] ^ d[i]) ? ((r >> 1) ^ 16'hA001) : (r >> 1);
    end
    return r;
  endfunction

  assign hs   = tx_valid && tx_ready;
  assign busy = (state != IDLE_S);

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE_S;
      data_out   <= 8'h00;
      tx_valid   <= 1'b0;
      crc        <= 16'hFFFF;
      byte_cnt   <= 7'd0;
      has_data_r <= 1'b0;
      zlp_r      <= 1'b0;
      last_r     <= 1'b0;
      cut_r      <= 1'b0;
      gap_cnt    <= '0;
      underrun   <= 1'b0;
    end else begin
      state      <= state_n;
      data_out   <= data_out_n;
      tx_valid   <= tx_valid_n;
      crc        <= crc_n;
      byte_cnt   <= byte_cnt_n;
      has_data_r <= has_data_n;
      zlp_r      <= zlp_n;
      last_r     <= last_n;
      cut_r      <= cut_n;
      gap_cnt    <= gap_n;
      underrun   <= underrun_n;
    end
  end

  always_comb begin
    state_n    = state;
    data_out_n = data_out;
    tx_valid_n = tx_valid;
    crc_n      = crc;
    byte_cnt_n = byte_cnt;
    has_data_n = has_data_r;
    zlp_n      = zlp_r;
    last_n     = last_r;
    cut_n      = cut_r;
    gap_n      = gap_cnt;
    underrun_n = 1'b0;
    pl_ready   = 1'b0;
    done       = 1'b0;
    step       = 1'b0;

    case (state)
      IDLE_S: begin
        if (pkt_start) begin
          data_out_n = {~pkt_pid, pkt_pid};
          tx_valid_n = 1'b1;
          crc_n      = 16'hFFFF;
          byte_cnt_n = 7'd0;
          has_data_n = pkt_has_data;
          zlp_n      = pkt_zlp;
          last_n     = 1'b0;
          cut_n      = 1'b0;
          gap_n      = '0;
          state_n    = PID_S;
        end
      end
      PID_S: begin
        if (hs) begin
          if (!has_data_r) begin
            tx_valid_n = 1'b0;
            state_n    = GAP_S;
          end else if (zlp_r) begin
            data_out_n = ~crc[7:0];
            state_n    = CRC_LO_S;
          end else begin
            step = 1'b1;
          end
        end
      end
      DATA_S: begin
        if (hs) begin
          if (last_r) begin
            data_out_n = ~crc[7:0];
            state_n    = CRC_LO_S;
          end else begin
            step = 1'b1;
          end
        end
      end
      CRC_LO_S: begin
        if (hs) begin
          data_out_n = ~crc[15:8];
          state_n    = CRC_HI_S;
        end
      end
      CRC_HI_S: begin
        if (hs) begin
          tx_valid_n = 1'b0;
          state_n    = GAP_S;
        end
      end
      GAP_S: begin
        if (gap_cnt == GW'(GAP_CYCLES - 1)) begin
          gap_n   = '0;
          done    = !cut_r;
          state_n = IDLE_S;
        end else begin
          gap_n = gap_cnt + GW'(1);
        end
      end
      default: state_n = IDLE_S;
    endcase

    // Payload fetch on a handshake: take the next byte, or truncate if none is ready.
    if (step) begin
      if (pl_valid) begin
        pl_ready   = 1'b1;
        data_out_n = pl_data;
        crc_n      = crc16_upd(crc, pl_data);
        last_n     = pl_last;
        byte_cnt_n = (byte_cnt == 7'd127) ? byte_cnt : byte_cnt + 7'd1;
        state_n    = DATA_S;
      end else begin
        tx_valid_n = 1'b0;
        underrun_n = 1'b1;
        cut_n      = 1'b1;
        state_n    = GAP_S;
      end
    end
  end

endmodule
